// File: rtl/coord_entry_pkg.sv
// Shared types and seven-segment constants for the coordinate entry front panel.
// Segment words are active-low, bit order {g,f,e,d,c,b,a}.
package coord_entry_pkg;

  typedef enum logic [2:0] {
    MODE_EDIT    = 3'd0,
    MODE_CONFIRM = 3'd1,
    MODE_PENDING = 3'd2,
    MODE_RUN     = 3'd3,
    MODE_PAUSE   = 3'd4
  } mode_t;

  localparam int KEY_CLEAR = 0;
  localparam int KEY_PAUSE = 1;
  localparam int KEY_START = 2;
  localparam int KEY_ENTER = 3;

  localparam logic [3:0] DIGIT_NONE = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'b1110111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_S     = 7'b0010010;

  localparam logic [13:0] GLYPH_EDIT = {SEG_E, SEG_D};
  localparam logic [13:0] GLYPH_ERR  = {SEG_E, SEG_R};
  localparam logic [20:0] GLYPH_RUN  = {SEG_R, SEG_U, SEG_N};
  localparam logic [27:0] GLYPH_PAUS = {SEG_P, SEG_A, SEG_U, SEG_S};

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/coord_entry_ctrl_key_edge.sv
// Push-key synchroniser with registered rising-edge pulse; the pulse appears
// three clock edges after the pin rises.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic pulse_r;

  // two-flop synchroniser followed by a registered edge detector
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      pulse_r <= sync2_r & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/coord_entry_ctrl.sv
// Front-panel controller: decimal X/Y entry from switches and keys, seven-segment
// feedback, valid/ready coordinate hand-off and run/pause/step/clear control.
module coord_entry_ctrl
  import coord_entry_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter int GRID_W         = 80,
  parameter int GRID_H         = 48,
  parameter int COORD_W        = 8,
  parameter int STARTUP_CYCLES = 100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                SW,
  input  logic [3:0]                KEY,
  output logic [7*(2*DIGITS+2)-1:0] hex,
  output logic [COORD_W-1:0]        coord_x,
  output logic [COORD_W-1:0]        coord_y,
  output logic                      coord_valid,
  input  logic                      coord_ready,
  output logic                      run,
  output logic                      step_pulse,
  output logic                      clear_pulse,
  output logic                      err
);

  localparam int NDIG  = 2 * DIGITS;
  localparam int NGRP  = NDIG + 2;
  localparam int HEX_W = 7 * NGRP;
  localparam int IDX_W = $clog2(NDIG + 1);
  localparam int ACC_W = COORD_W + 4;
  localparam int HO_W  = $clog2(STARTUP_CYCLES + 2);

  logic [3:0]               key_pulse_s;
  logic [3:0]               ev_s;
  logic [3:0]               sw_digit_s;
  logic [ACC_W-1:0]         acc_x_s;
  logic [ACC_W-1:0]         acc_y_s;

  mode_t                    mode_r,    mode_n;
  logic [IDX_W-1:0]         idx_r,     idx_n;
  logic [NDIG-1:0][3:0]     digits_r,  digits_n;
  logic [COORD_W-1:0]       x_r,       x_n;
  logic [COORD_W-1:0]       y_r,       y_n;
  logic                     valid_r,   valid_n;
  logic                     run_r,     run_n;
  logic                     err_r,     err_n;
  logic                     step_r,    step_n;
  logic                     clear_r,   clear_n;
  logic [HO_W-1:0]          holdoff_r, holdoff_n;
  logic [HEX_W-1:0]         hex_r,     hex_n;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_edge u_key_edge (
      .clk   (clk),
      .reset (reset),
      .key   (KEY[k]),
      .pulse (key_pulse_s[k])
    );
  end

  // X digits on the left, mode glyph pair in the middle, Y digits on the right
  function automatic logic [HEX_W-1:0] build_hex(input mode_t m,
                                                 input logic [NDIG-1:0][3:0] d,
                                                 input logic e);
    logic [HEX_W-1:0] h;
    h = {NGRP{SEG_OFF}};
    case (m)
      MODE_RUN:   h[HEX_W-1 -: 21] = GLYPH_RUN;
      MODE_PAUSE: h[HEX_W-1 -: 28] = GLYPH_PAUS;
      default: begin
        for (int k = 0; k < DIGITS; k++) begin
          h[7*(NGRP-1-k) +: 7] = seg_decode(d[k]);
          h[7*(DIGITS-1-k) +: 7] = seg_decode(d[DIGITS+k]);
        end
        h[7*DIGITS +: 14] = e ? GLYPH_ERR : GLYPH_EDIT;
      end
    endcase
    return h;
  endfunction

  // switch decode (highest index wins) and decimal accumulation of the entered digits
  always_comb begin
    sw_digit_s = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (SW[i]) sw_digit_s = 4'(i);
      else       sw_digit_s = sw_digit_s;
    end
    acc_x_s = '0;
    acc_y_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      acc_x_s = acc_x_s * ACC_W'(10) + ACC_W'(digits_r[i]);
      acc_y_s = acc_y_s * ACC_W'(10) + ACC_W'(digits_r[DIGITS+i]);
    end
  end

  // next-state: handshake first, then the single highest-priority key event
  always_comb begin
    mode_n    = mode_r;
    idx_n     = idx_r;
    digits_n  = digits_r;
    x_n       = x_r;
    y_n       = y_r;
    valid_n   = valid_r;
    run_n     = run_r;
    err_n     = err_r;
    step_n    = 1'b0;
    clear_n   = 1'b0;
    holdoff_n = (holdoff_r != '0) ? holdoff_r - HO_W'(1) : holdoff_r;
    ev_s      = key_pulse_s & {4{holdoff_r == '0}};

    if (mode_r == MODE_PENDING && valid_r && coord_ready) begin
      valid_n = 1'b0;
      mode_n  = MODE_EDIT;
    end else begin
      valid_n = valid_r;
    end

    if (ev_s[KEY_CLEAR]) begin
      clear_n  = 1'b1;
      valid_n  = 1'b0;
      run_n    = 1'b0;
      err_n    = 1'b0;
      digits_n = {NDIG{DIGIT_NONE}};
      idx_n    = '0;
      mode_n   = MODE_EDIT;
    end else if (ev_s[KEY_ENTER]) begin
      case (mode_r)
        MODE_EDIT: begin
          if (SW != 10'd0) begin
            for (int i = 0; i < NDIG; i++) begin
              if (idx_r == IDX_W'(i)) digits_n[i] = sw_digit_s;
              else                    digits_n[i] = digits_r[i];
            end
            err_n  = 1'b0;
            idx_n  = idx_r + IDX_W'(1);
            mode_n = (idx_r == IDX_W'(NDIG-1)) ? MODE_CONFIRM : MODE_EDIT;
          end else begin
            idx_n = idx_r;
          end
        end
        MODE_CONFIRM: begin
          if (acc_x_s < ACC_W'(GRID_W) && acc_y_s < ACC_W'(GRID_H)) begin
            x_n     = acc_x_s[COORD_W-1:0];
            y_n     = acc_y_s[COORD_W-1:0];
            valid_n = 1'b1;
            err_n   = 1'b0;
            mode_n  = MODE_PENDING;
          end else begin
            err_n   = 1'b1;
            mode_n  = MODE_EDIT;
          end
          digits_n = {NDIG{DIGIT_NONE}};
          idx_n    = '0;
        end
        default: mode_n = mode_n;
      endcase
    end else if (ev_s[KEY_START]) begin
      case (mode_r)
        MODE_EDIT, MODE_CONFIRM: begin
          mode_n   = MODE_RUN;
          run_n    = 1'b1;
          digits_n = {NDIG{DIGIT_NONE}};
          idx_n    = '0;
        end
        MODE_PAUSE: begin
          mode_n = MODE_RUN;
          run_n  = 1'b1;
        end
        default: mode_n = mode_n;
      endcase
    end else if (ev_s[KEY_PAUSE]) begin
      case (mode_r)
        MODE_RUN: begin
          mode_n = MODE_PAUSE;
          run_n  = 1'b0;
        end
        MODE_PAUSE: step_n = 1'b1;
        default:    mode_n = mode_n;
      endcase
    end else begin
      step_n = 1'b0;
    end

    hex_n = build_hex(mode_n, digits_n, err_n);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r    <= MODE_EDIT;
      idx_r     <= '0;
      digits_r  <= {NDIG{DIGIT_NONE}};
      x_r       <= '0;
      y_r       <= '0;
      valid_r   <= 1'b0;
      run_r     <= 1'b0;
      err_r     <= 1'b0;
      step_r    <= 1'b0;
      clear_r   <= 1'b0;
      holdoff_r <= HO_W'(STARTUP_CYCLES);
      hex_r     <= build_hex(MODE_EDIT, {NDIG{DIGIT_NONE}}, 1'b0);
    end else begin
      mode_r    <= mode_n;
      idx_r     <= idx_n;
      digits_r  <= digits_n;
      x_r       <= x_n;
      y_r       <= y_n;
      valid_r   <= valid_n;
      run_r     <= run_n;
      err_r     <= err_n;
      step_r    <= step_n;
      clear_r   <= clear_n;
      holdoff_r <= holdoff_n;
      hex_r     <= hex_n;
    end
  end

  assign hex         = hex_r;
  assign coord_x     = x_r;
  assign coord_y     = y_r;
  assign coord_valid = valid_r;
  assign run         = run_r;
  assign step_pulse  = step_r;
  assign clear_pulse = clear_r;
  assign err         = err_r;

endmodule
